// File: rtl/serial_bit_streamer_if.sv
// Word-load handshake between a producer and the serial bit streamer.
// The producer holds load_valid/load_data; the streamer answers with load_ready.
interface serial_bit_streamer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/serial_bit_streamer.sv
// Parallel-to-serial converter: handshaked WIDTH-bit words out as one bit per clock,
// with a one-word holding buffer so consecutive words stream without gaps.
module serial_bit_streamer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_bit_streamer_if.slave load,
  output logic                 data_out,
  output logic                 bit_valid,
  output logic                 last_bit
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_reg, shift_reg_nx;
  logic [WIDTH-1:0] hold_reg, hold_reg_nx;
  logic             hold_full, hold_full_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             xfer;

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] sr);
    if (MSB_FIRST) advance = {sr[WIDTH-2:0], 1'b0};
    else           advance = {1'b0, sr[WIDTH-1:1]};
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] sr);
    head_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  endfunction

  assign load.load_ready = !hold_full;
  assign xfer            = load.load_valid && !hold_full;

  always_comb begin
    state_nx     = state;
    shift_reg_nx = shift_reg;
    hold_reg_nx  = hold_reg;
    hold_full_nx = hold_full;
    cnt_nx       = cnt;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          shift_reg_nx = load.load_data;
          cnt_nx       = '0;
          state_nx     = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != CNT_LAST) begin
          shift_reg_nx = advance(shift_reg);
          cnt_nx       = cnt + 1'b1;
          if (xfer) begin
            hold_reg_nx  = load.load_data;
            hold_full_nx = 1'b1;
          end
        end else if (hold_full) begin
          // Held word takes over at the word boundary; no transfer is possible here.
          shift_reg_nx = hold_reg;
          hold_full_nx = 1'b0;
          cnt_nx       = '0;
        end else if (xfer) begin
          shift_reg_nx = load.load_data;
          cnt_nx       = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state: cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nx;
      hold_full <= hold_full_nx;
      cnt       <= cnt_nx;
    end
  end

  // Word data: only meaningful while the control state marks it live.
  always_ff @(posedge clk) begin
    shift_reg <= shift_reg_nx;
    hold_reg  <= hold_reg_nx;
  end

  assign bit_valid = (state == SHIFT);
  assign data_out  = (state == SHIFT) ? head_bit(shift_reg) : IDLE_LEVEL;
  assign last_bit  = (state == SHIFT) && (cnt == CNT_LAST);

endmodule

// File: tb/tb_serial_bit_streamer.sv
// Bench for serial_bit_streamer: two lanes (MSB-first/idle-0 and LSB-first/idle-1)
// share stimulus; a bit-queue model predicts each lane's stream and readiness.
module tb_serial_bit_streamer;
  localparam int       W      = 8;
  localparam bit [1:0] MSBF   = 2'b01;
  localparam bit [1:0] IDLE_L = 2'b10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         lv = 1'b0;
  logic [W-1:0] ld = '0;

  logic [1:0] dout, bv, lb, rdy;

  int vectors = 0;
  int miscompares = 0;

  // Model state per lane: bits not yet presented, and expected {bit,last} stream.
  int       pend [2];
  bit [1:0] exp_q [2][$];

  always #5 clk = ~clk;

  serial_bit_streamer_if #(.WIDTH(W)) if0 ();
  serial_bit_streamer_if #(.WIDTH(W)) if1 ();

  assign if0.load_valid = lv;
  assign if0.load_data  = ld;
  assign if1.load_valid = lv;
  assign if1.load_data  = ld;
  assign rdy = {if1.load_ready, if0.load_ready};

  serial_bit_streamer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .reset(reset), .load(if0),
    .data_out(dout[0]), .bit_valid(bv[0]), .last_bit(lb[0])
  );

  serial_bit_streamer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u1 (
    .clk(clk), .reset(reset), .load(if1),
    .data_out(dout[1]), .bit_valid(bv[1]), .last_bit(lb[1])
  );

  task automatic chk(input string name, input int lane, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s lane%0d t=%0t got %b want %b", name, lane, $time, act, exp);
    end
  endtask

  // Reference model: a lane is a FIFO of bits draining one per clock.
  // It can take a word whenever at most one word's worth of bits is still pending.
  always @(posedge clk or posedge reset) begin
    for (int l = 0; l < 2; l++) begin
      if (reset) begin
        pend[l] = 0;
        exp_q[l].delete();
      end else begin
        bit acc;
        acc = lv && (pend[l] <= W);
        if (pend[l] > 0) pend[l]--;
        if (acc) begin
          for (int i = 0; i < W; i++) begin
            bit b;
            b = MSBF[l] ? ld[W-1-i] : ld[i];
            exp_q[l].push_back({b, (i == W-1)});
          end
          pend[l] += W;
        end
      end
    end
  end

  // Monitor: pops one expected bit whenever a lane presents a valid bit.
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      chk("load_ready", l, rdy[l], pend[l] <= W);
      chk("bit_valid", l, bv[l], pend[l] != 0);
      if (bv[l] === 1'b1) begin
        if (exp_q[l].size() == 0) begin
          chk("unexpected_bit", l, bv[l], 1'b0);
        end else begin
          bit [1:0] e;
          e = exp_q[l].pop_front();
          chk("data_out", l, dout[l], e[1]);
          chk("last_bit", l, lb[l], e[0]);
        end
      end else begin
        chk("idle_level", l, dout[l], IDLE_L[l]);
        chk("idle_last", l, lb[l], 1'b0);
      end
    end
  end

  task automatic check_reset_outputs();
    for (int l = 0; l < 2; l++) begin
      chk("rst_data_out", l, dout[l], IDLE_L[l]);
      chk("rst_bit_valid", l, bv[l], 1'b0);
      chk("rst_last_bit", l, lb[l], 1'b0);
      chk("rst_load_ready", l, rdy[l], 1'b1);
    end
  endtask

  // Present a word and hold it until the lane-0 handshake completes.
  task automatic send(input logic [W-1:0] w);
    int n;
    lv = 1'b1;
    ld = w;
    n  = 0;
    while (if0.load_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout word %h got no load_ready want load_ready within 40 cycles", w);
    end
    @(negedge clk);
    lv = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    lv = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    send(8'hB5);
    idle_cycles(10);

    send(8'hA5);
    send(8'h5A);
    send(8'hFF);
    idle_cycles(20);

    send(8'hF0);
    send(8'h3C);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(12);

    send(8'h01);
    idle_cycles(10);
    send(8'hA0);
    idle_cycles(10);

    for (int c = 0; c < 400; c++) begin
      lv = ($urandom_range(0, 3) != 0);
      ld = W'($urandom);
      @(negedge clk);
    end

    lv = 1'b0;
    n  = 0;
    while ((pend[0] != 0 || pend[1] != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      vectors++;
      if (exp_q[l].size() != 0) begin
        miscompares++;
        $display("FAIL drain lane%0d got %0d undelivered bits want 0", l, exp_q[l].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
